muldiv_hilo: RTL and testbench



---
 rtl/muldiv_hilo.sv | 161 ++++++++++++++++
 tb/tb_muldiv_hilo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo.sv
// HI/LO architectural registers with mult capture, mthi/mtlo, and an iterative restoring div/divu engine.
// Optional MULDIV_DZ_FLAG_EN adds a sticky div_zero status output.
module muldiv_hilo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_div,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_we,
  input  logic [WIDTH-1:0] alu_hi,
  input  logic [WIDTH-1:0] alu_lo,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULDIV_DZ_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] rem, rem_nxt;
  logic [WIDTH-1:0] quo, quo_nxt;
  logic [WIDTH-1:0] dvs, dvs_nxt;
  logic [WIDTH-1:0] a_raw, a_raw_nxt;
  logic             neg_q, neg_q_nxt;
  logic             neg_r, neg_r_nxt;
  logic             dz, dz_nxt;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

`ifdef MULDIV_DZ_FLAG_EN
  logic div_zero_nxt;
`endif

  assign busy = (state != IDLE);

  // Operand magnitudes; only signed divides with a set MSB are negated.
  assign a_mag = (div_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (div_signed && b[WIDTH-1]) ? -b : b;

  // One restoring step: remainder < divisor keeps the true difference within WIDTH bits.
  assign shifted = {rem, quo[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, dvs});
  assign diff    = shifted[WIDTH-1:0] - dvs;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rem_nxt   = rem;
    quo_nxt   = quo;
    dvs_nxt   = dvs;
    a_raw_nxt = a_raw;
    neg_q_nxt = neg_q;
    neg_r_nxt = neg_r;
    dz_nxt    = dz;
    hi_nxt    = hi;
    lo_nxt    = lo;
`ifdef MULDIV_DZ_FLAG_EN
    div_zero_nxt = div_zero;
`endif

    case (state)
      IDLE: begin
        if (start_div) begin
          quo_nxt   = a_mag;
          dvs_nxt   = b_mag;
          a_raw_nxt = a;
          neg_q_nxt = div_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r_nxt = div_signed & a[WIDTH-1];
          dz_nxt    = (b == '0);
          rem_nxt   = '0;
          cnt_nxt   = CW'(WIDTH - 1);
          state_nxt = DIV;
        end else if (hilo_we) begin
          hi_nxt = alu_hi;
          lo_nxt = alu_lo;
        end else begin
          if (mthi) hi_nxt = a;
          if (mtlo) lo_nxt = a;
        end
`ifdef MULDIV_DZ_FLAG_EN
        if (start_div || hilo_we || mthi || mtlo) div_zero_nxt = 1'b0;
`endif
      end

      DIV: begin
        rem_nxt = ge ? diff : shifted[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], ge};
        if (cnt == '0) state_nxt = FIX;
        else           cnt_nxt   = cnt - CW'(1);
      end

      FIX: begin
        // Divide by zero bypasses sign correction entirely.
        if (dz) begin
          hi_nxt = a_raw;
          lo_nxt = '1;
        end else begin
          hi_nxt = neg_r ? -rem : rem;
          lo_nxt = neg_q ? -quo : quo;
        end
`ifdef MULDIV_DZ_FLAG_EN
        div_zero_nxt = dz;
`endif
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      a_raw <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef MULDIV_DZ_FLAG_EN
      div_zero <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rem   <= rem_nxt;
      quo   <= quo_nxt;
      dvs   <= dvs_nxt;
      a_raw <= a_raw_nxt;
      neg_q <= neg_q_nxt;
      neg_r <= neg_r_nxt;
      dz    <= dz_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
`ifdef MULDIV_DZ_FLAG_EN
      div_zero <= div_zero_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: directed cases plus randomized divides and idle writes
// checked against an arithmetic reference model.
module tb_muldiv_hilo;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_div;
  logic        div_signed;
  logic [31:0] a, b;
  logic        hilo_we;
  logic [31:0] alu_hi, alu_lo;
  logic        mthi, mtlo;
  logic        busy;
  logic [31:0] hi, lo;
`ifdef MULDIV_DZ_FLAG_EN
  logic        div_zero;
`endif

  int vec = 0;
  int errs = 0;

  muldiv_hilo #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start_div(start_div), .div_signed(div_signed),
    .a(a), .b(b), .hilo_we(hilo_we), .alu_hi(alu_hi), .alu_lo(alu_lo),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .hi(hi), .lo(lo)
`ifdef MULDIV_DZ_FLAG_EN
    , .div_zero(div_zero)
`endif
  );

  always #5 clk = ~clk;

  // Reference: MIPS div/divu semantics via plain integer arithmetic; returns {hi, lo}.
  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy, q, r;
    logic [31:0] uq, ur;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      return {r[31:0], q[31:0]};
    end
    uq = x / y;
    ur = x % y;
    return {ur, uq};
  endfunction

  // Starts a divide and returns the number of sampled cycles with busy high (bounded).
  task automatic do_div(input logic [31:0] x, input logic [31:0] y, input logic s, output int cyc);
    @(negedge clk);
    a = x; b = y; div_signed = s; start_div = 1'b1;
    @(posedge clk); #1;
    start_div = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start_div = 0; div_signed = 0; a = 0; b = 0;
    hilo_we = 0; alu_hi = 0; alu_lo = 0; mthi = 0; mtlo = 0;
    #1;
    vec++; if (busy !== 1'b0)  begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vec++; if (hi !== 32'd0)   begin errs++; $display("FAIL reset_hi: got %h expected 0", hi); end
    vec++; if (lo !== 32'd0)   begin errs++; $display("FAIL reset_lo: got %h expected 0", lo); end
`ifdef MULDIV_DZ_FLAG_EN
    vec++; if (div_zero !== 1'b0) begin errs++; $display("FAIL reset_dz: got %b expected 0", div_zero); end
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_divu;
    int c;
    do_div(32'd100, 32'd7, 1'b0, c);
    vec++; if (c != 33)        begin errs++; $display("FAIL divu_busy_cycles: got %0d expected 33", c); end
    vec++; if (lo !== 32'd14)  begin errs++; $display("FAIL divu_lo: got %h expected %h", lo, 32'd14); end
    vec++; if (hi !== 32'd2)   begin errs++; $display("FAIL divu_hi: got %h expected %h", hi, 32'd2); end
  endtask

  task automatic test_div_signed;
    int c;
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, c);
    vec++; if (lo !== 32'hFFFF_FFFD) begin errs++; $display("FAIL sdiv1_lo: got %h expected fffffffd", lo); end
    vec++; if (hi !== 32'hFFFF_FFFF) begin errs++; $display("FAIL sdiv1_hi: got %h expected ffffffff", hi); end
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, c);
    vec++; if (lo !== 32'hFFFF_FFFD) begin errs++; $display("FAIL sdiv2_lo: got %h expected fffffffd", lo); end
    vec++; if (hi !== 32'd1)         begin errs++; $display("FAIL sdiv2_hi: got %h expected 1", hi); end
  endtask

  task automatic test_div_special;
    int c;
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, c);
    vec++; if (lo !== 32'h8000_0000) begin errs++; $display("FAIL ovf_lo: got %h expected 80000000", lo); end
    vec++; if (hi !== 32'd0)         begin errs++; $display("FAIL ovf_hi: got %h expected 0", hi); end
    do_div(32'd5, 32'd0, 1'b0, c);
    vec++; if (c != 33)              begin errs++; $display("FAIL dz_busy_cycles: got %0d expected 33", c); end
    vec++; if (hi !== 32'd5)         begin errs++; $display("FAIL dz_hi: got %h expected 5", hi); end
    vec++; if (lo !== 32'hFFFF_FFFF) begin errs++; $display("FAIL dz_lo: got %h expected ffffffff", lo); end
`ifdef MULDIV_DZ_FLAG_EN
    vec++; if (div_zero !== 1'b1)    begin errs++; $display("FAIL dz_flag: got %b expected 1", div_zero); end
`endif
  endtask

  task automatic test_priority;
    @(negedge clk);
    hilo_we = 1; alu_hi = 32'h1234_5678; alu_lo = 32'h9ABC_DEF0;
    mthi = 1; mtlo = 1; a = 32'hA5;
    @(posedge clk); #1;
    vec++; if (hi !== 32'h1234_5678) begin errs++; $display("FAIL prio_hilo_hi: got %h expected 12345678", hi); end
    vec++; if (lo !== 32'h9ABC_DEF0) begin errs++; $display("FAIL prio_hilo_lo: got %h expected 9abcdef0", lo); end
`ifdef MULDIV_DZ_FLAG_EN
    vec++; if (div_zero !== 1'b0)    begin errs++; $display("FAIL prio_dz_clear: got %b expected 0", div_zero); end
`endif
    @(negedge clk);
    hilo_we = 0;
    @(posedge clk); #1;
    mthi = 0; mtlo = 0;
    vec++; if (hi !== 32'hA5) begin errs++; $display("FAIL prio_mthi: got %h expected a5", hi); end
    vec++; if (lo !== 32'hA5) begin errs++; $display("FAIL prio_mtlo: got %h expected a5", lo); end
  endtask

  task automatic test_hold;
    int c;
    @(negedge clk);
    a = 32'd100; b = 32'd7; div_signed = 0; start_div = 1;
    @(posedge clk); #1;
    start_div = 0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    a = 32'h55; mthi = 1; hilo_we = 1; alu_hi = 32'hDEAD_BEEF; alu_lo = 32'hCAFE_F00D; start_div = 1;
    @(posedge clk); #1;
    mthi = 0; hilo_we = 0; start_div = 0;
    vec++; if (hi !== 32'hA5 || lo !== 32'hA5) begin
      errs++; $display("FAIL hold_writes: got hi=%h lo=%h expected a5/a5", hi, lo);
    end
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL hold_busy: got %b expected 1", busy); end
    c = 0;
    while (busy && c < 100) begin
      c++;
      vec++; if (hi !== 32'hA5 || lo !== 32'hA5) begin
        errs++; $display("FAIL hold_inflight: got hi=%h lo=%h expected a5/a5", hi, lo);
      end
      @(posedge clk); #1;
    end
    vec++; if (c >= 100) begin errs++; $display("FAIL hold_timeout: got %0d cycles expected <100", c); end
    vec++; if (hi !== 32'd2 || lo !== 32'd14) begin
      errs++; $display("FAIL hold_result: got hi=%h lo=%h expected 2/e", hi, lo);
    end
  endtask

  task automatic test_reset_mid;
    int c;
    @(negedge clk);
    a = 32'd100; b = 32'd7; div_signed = 0; start_div = 1;
    @(posedge clk); #1;
    start_div = 0;
    repeat (14) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    vec++; if (hi !== 32'd0 || lo !== 32'd0) begin
      errs++; $display("FAIL rstmid_hilo: got hi=%h lo=%h expected 0/0", hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    do_div(32'd9, 32'd4, 1'b0, c);
    vec++; if (c != 33) begin errs++; $display("FAIL rstmid_cycles: got %0d expected 33", c); end
    vec++; if (lo !== 32'd2 || hi !== 32'd1) begin
      errs++; $display("FAIL rstmid_div: got hi=%h lo=%h expected 1/2", hi, lo);
    end
  endtask

  task automatic test_random;
    int c;
    logic [31:0] x, y;
    logic        s;
    logic [63:0] exp;
    logic [31:0] mh, ml;
    for (int i = 0; i < 40; i++) begin
      x = $urandom; y = $urandom; s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) y = 32'd0;
      if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; s = 1'b1; end
      exp = ref_div(x, y, s);
      do_div(x, y, s, c);
      vec++; if (c != 33) begin errs++; $display("FAIL rnd_cycles[%0d]: got %0d expected 33", i, c); end
      vec++; if ({hi, lo} !== exp) begin
        errs++; $display("FAIL rnd_div[%0d] a=%h b=%h s=%b: got %h_%h expected %h_%h", i, x, y, s, hi, lo, exp[63:32], exp[31:0]);
      end
`ifdef MULDIV_DZ_FLAG_EN
      vec++; if (div_zero !== (y == 32'd0)) begin
        errs++; $display("FAIL rnd_dz[%0d]: got %b expected %b", i, div_zero, (y == 32'd0));
      end
`endif
      mh = hi; ml = lo;
      @(negedge clk);
      hilo_we = 1'($urandom_range(0, 1)); mthi = 1'($urandom_range(0, 1)); mtlo = 1'($urandom_range(0, 1));
      alu_hi = $urandom; alu_lo = $urandom; a = $urandom;
      if (hilo_we) begin mh = alu_hi; ml = alu_lo; end
      else begin
        if (mthi) mh = a;
        if (mtlo) ml = a;
      end
      @(posedge clk); #1;
      hilo_we = 0; mthi = 0; mtlo = 0;
      vec++; if (hi !== mh || lo !== ml) begin
        errs++; $display("FAIL rnd_idle[%0d]: got %h_%h expected %h_%h", i, hi, lo, mh, ml);
      end
    end
  endtask

  initial begin
    test_reset;
    test_divu;
    test_div_signed;
    test_div_special;
    test_priority;
    test_hold;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
